divbysmall_seq: RTL

- Sequential small-constant divider: the inverse of the datapath's multiply-by-1..4 block.
- Takes a DW-bit value and a one-hot divisor select. Returns quotient, remainder and two status flags.
- Restoring division, one quotient bit per clock, behind a start/busy/done handshake.
- Sits downstream of the multiplier stage to recover the original operand and check that it was an exact multiple.

---
 rtl/divbysmall_seq_if.sv | 15 +
 rtl/divbysmall_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/divbysmall_seq_if.sv
// Handshake/result bundle for divbysmall_seq: start/i/m in, busy/done/q/r/exact/fits out.
interface divbysmall_seq_if #(parameter int DW = 10);
  logic          start;
  logic [DW-1:0] i;
  logic [4:0]    m;
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  logic [1:0]    r;
  logic          exact;
  logic          fits;

  modport master (output start, i, m, input busy, done, q, r, exact, fits);
  modport slave  (input start, i, m, output busy, done, q, r, exact, fits);
endinterface

// File: rtl/divbysmall_seq.sv
// Sequential restoring divider by 1..4 (one quotient bit per clock), start/busy/done handshake.
// Optional macro DIVSHIFT_FAST_EN: divisors 1/2/4 resolve by shift on the accepting edge.
module divbysmall_seq #(
  parameter int DW = 10,
  parameter int NW = 8
) (
  input  logic           clk,
  input  logic           rst,
  divbysmall_seq_if.slave bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [1:0]    r;
    logic          exact;
    logic          fits;
  } res_t;

  state_t        state, state_n;
  logic [DW-1:0] dsr, dsr_n;
  logic [2:0]    rem, rem_n;
  logic [3:0]    remx;
  logic [2:0]    d, d_dec;
  logic [CW-1:0] cnt;
  logic          qbit, accept, fast, res_ld;
  logic [DW-1:0] res_q;
  logic [1:0]    res_r;
  res_t          res;

  // Lowest set index among m[1..4] wins; anything else divides by 1.
  always_comb begin
    d_dec = 3'd1;
    if      (bus.m[1]) d_dec = 3'd1;
    else if (bus.m[2]) d_dec = 3'd2;
    else if (bus.m[3]) d_dec = 3'd3;
    else if (bus.m[4]) d_dec = 3'd4;
  end

  assign accept = bus.start && (state != RUN);

`ifdef DIVSHIFT_FAST_EN
  assign fast = (d_dec != 3'd3);
`else
  assign fast = 1'b0;
`endif

  // One restoring step; the shift register doubles as dividend source and quotient sink.
  always_comb begin
    remx  = {rem, dsr[DW-1]};
    qbit  = (remx >= {1'b0, d});
    rem_n = qbit ? 3'(remx - {1'b0, d}) : remx[2:0];
    dsr_n = (dsr << 1) | DW'(qbit);
  end

  always_comb begin
    res_ld = (state == RUN) && (cnt == '0);
    res_q  = dsr_n;
    res_r  = rem_n[1:0];
`ifdef DIVSHIFT_FAST_EN
    if (accept && fast) begin
      res_ld = 1'b1;
      case (d_dec)
        3'd2:    begin res_q = bus.i >> 1; res_r = {1'b0, bus.i[0]}; end
        3'd4:    begin res_q = bus.i >> 2; res_r = bus.i[1:0];       end
        default: begin res_q = bus.i;      res_r = 2'd0;             end
      endcase
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = accept ? (fast ? DONE : RUN) : IDLE;
      RUN:        if (cnt == '0) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsr <= '0;
      rem <= '0;
      d   <= 3'd1;
      cnt <= '0;
    end else if (accept) begin
      dsr <= bus.i;
      rem <= '0;
      d   <= d_dec;
      cnt <= CW'(DW - 1);
    end else if (state == RUN) begin
      dsr <= dsr_n;
      rem <= rem_n;
      cnt <= cnt - 1'b1;
    end
  end

  // Results only move on completion; a new capture leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '{q: '0, r: 2'd0, exact: 1'b1, fits: 1'b1};
    end else if (res_ld) begin
      res.q     <= res_q;
      res.r     <= res_r;
      res.exact <= (res_r == 2'd0);
      res.fits  <= ((res_q >> NW) == '0);
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.q     = res.q;
  assign bus.r     = res.r;
  assign bus.exact = res.exact;
  assign bus.fits  = res.fits;
endmodule
